arm_banked_regfile: RTL and testbench

- Parametrised successor to the flat `registers` block: the ARM7TDMI register file with architectural mode banking (USR/SYS, FIQ, IRQ, SVC, ABT, UND).
- Provides NUM_RD combinational read ports, one write port, a CPSR with NZCV flag update, and per-mode SPSRs.
- Adds atomic exception entry and return sequencing, plus an optional write-to-read bypass.
- Sits between decode (read ports) and writeback/exception control in the core.

---
 rtl/arm_regs_pkg.sv | 65 ++++++
 rtl/arm_reg_bank_map.sv | 28 ++
 rtl/arm_banked_regfile.sv | 113 +++++++++++
 tb/tb_arm_banked_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_regs_pkg.sv
// Shared definitions for the ARM7TDMI banked register file: mode encodings,
// CPSR bit positions and the physical register / SPSR numbering.
package arm_regs_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  localparam int CPSR_N        = 31;
  localparam int CPSR_Z        = 30;
  localparam int CPSR_C        = 29;
  localparam int CPSR_V        = 28;
  localparam int CPSR_I        = 7;
  localparam int CPSR_F        = 6;
  localparam int CPSR_MODE_MSB = 4;
  localparam int CPSR_MODE_LSB = 0;

  // Only NZCV, I, F and the mode field exist; every other CPSR bit reads 0.
  localparam logic [31:0] CPSR_MASK = 32'hF00000DF;

  localparam int NUM_PHYS_GPR = 31;
  localparam int NUM_SPSR     = 5;

  // Physical numbering: 0..15 user bank, then FIQ R8-R14, then R13/R14 pairs.
  localparam logic [4:0] PHYS_FIQ_R8  = 5'd16;
  localparam logic [4:0] PHYS_IRQ_R13 = 5'd23;
  localparam logic [4:0] PHYS_IRQ_R14 = 5'd24;
  localparam logic [4:0] PHYS_SVC_R13 = 5'd25;
  localparam logic [4:0] PHYS_SVC_R14 = 5'd26;
  localparam logic [4:0] PHYS_ABT_R13 = 5'd27;
  localparam logic [4:0] PHYS_ABT_R14 = 5'd28;
  localparam logic [4:0] PHYS_UND_R13 = 5'd29;
  localparam logic [4:0] PHYS_UND_R14 = 5'd30;

  localparam logic [2:0] SPSR_FIQ = 3'd0;
  localparam logic [2:0] SPSR_IRQ = 3'd1;
  localparam logic [2:0] SPSR_SVC = 3'd2;
  localparam logic [2:0] SPSR_ABT = 3'd3;
  localparam logic [2:0] SPSR_UND = 3'd4;

  function automatic logic has_spsr(input logic [4:0] mode);
    case (mode)
      MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: has_spsr = 1'b1;
      default:                                          has_spsr = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] spsr_index(input logic [4:0] mode);
    case (mode)
      MODE_FIQ: spsr_index = SPSR_FIQ;
      MODE_IRQ: spsr_index = SPSR_IRQ;
      MODE_SVC: spsr_index = SPSR_SVC;
      MODE_ABT: spsr_index = SPSR_ABT;
      MODE_UND: spsr_index = SPSR_UND;
      default:  spsr_index = SPSR_FIQ;
    endcase
  endfunction

endpackage

// File: rtl/arm_reg_bank_map.sv
// Maps (processor mode, architectural register) onto the 5-bit physical index.
module arm_reg_bank_map
  import arm_regs_pkg::*;
(
  input  logic [4:0] i_mode,
  input  logic [3:0] i_arch,
  output logic [4:0] o_phys
);

  // Unknown mode encodings fall through to the user bank.
  always_comb begin
    o_phys = {1'b0, i_arch};
    case (i_mode)
      MODE_FIQ: if (i_arch >= 4'd8 && i_arch <= 4'd14)
                  o_phys = PHYS_FIQ_R8 + {2'b00, i_arch[2:0]};
      MODE_IRQ: if (i_arch == 4'd13) o_phys = PHYS_IRQ_R13;
                else if (i_arch == 4'd14) o_phys = PHYS_IRQ_R14;
      MODE_SVC: if (i_arch == 4'd13) o_phys = PHYS_SVC_R13;
                else if (i_arch == 4'd14) o_phys = PHYS_SVC_R14;
      MODE_ABT: if (i_arch == 4'd13) o_phys = PHYS_ABT_R13;
                else if (i_arch == 4'd14) o_phys = PHYS_ABT_R14;
      MODE_UND: if (i_arch == 4'd13) o_phys = PHYS_UND_R13;
                else if (i_arch == 4'd14) o_phys = PHYS_UND_R14;
      default: ;
    endcase
  end

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM7TDMI register file with mode banking, CPSR/SPSRs, single-edge exception
// entry/return and optional write-to-read forwarding.
module arm_banked_regfile
  import arm_regs_pkg::*;
#(
  parameter int         NUM_RD     = 3,
  parameter bit         BYPASS     = 1'b1,
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*NUM_RD-1:0]   rd_addr,
  output logic [32*NUM_RD-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  flag_we,
  input  logic [3:0]            flags_in,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_mode,
  input  logic [31:0]           exc_lr,
  input  logic                  ret_valid,
  output logic [31:0]           cpsr,
  output logic [31:0]           spsr
);

  logic [31:0] r_gpr  [NUM_PHYS_GPR];
  logic [31:0] r_spsr [NUM_SPSR];
  logic [31:0] r_cpsr;

  logic [4:0]  w_mode;
  logic [4:0]  w_wr_phys;
  logic [4:0]  w_lr_phys;
  logic        w_exc_take;
  logic        w_ret_take;
  logic        w_exc_f;
  logic [3:0]  w_flags_now;
  logic [31:0] w_spsr_cur;
  logic [31:0] w_cpsr_to_spsr;
  logic [31:0] w_cpsr_exc;

  assign w_mode      = r_cpsr[CPSR_MODE_MSB:CPSR_MODE_LSB];
  assign w_exc_take  = exc_valid && has_spsr(exc_mode);
  assign w_ret_take  = ret_valid && has_spsr(w_mode);
  assign w_exc_f     = (exc_mode == MODE_FIQ) ? 1'b1 : r_cpsr[CPSR_F];
  assign w_flags_now = flag_we ? flags_in : r_cpsr[CPSR_N:CPSR_V];
  assign w_spsr_cur  = has_spsr(w_mode) ? r_spsr[spsr_index(w_mode)] : 32'h0;

  // The saved copy sees this cycle's flag update; the live CPSR does not,
  // because exception entry outranks flag_we.
  assign w_cpsr_to_spsr = {w_flags_now, r_cpsr[27:0]};
  assign w_cpsr_exc     = {r_cpsr[CPSR_N:CPSR_V], 20'b0, 1'b1, w_exc_f, 1'b0, exc_mode};

  arm_reg_bank_map u_wr_map (
    .i_mode (w_mode),
    .i_arch (wr_addr),
    .o_phys (w_wr_phys)
  );

  arm_reg_bank_map u_lr_map (
    .i_mode (exc_mode),
    .i_arch (4'd14),
    .o_phys (w_lr_phys)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [4:0]  w_phys;
    logic [31:0] w_data;

    arm_reg_bank_map u_rd_map (
      .i_mode (w_mode),
      .i_arch (rd_addr[4*k +: 4]),
      .o_phys (w_phys)
    );

    // Forwarding compares physical indices so banked aliases never collide.
    always_comb begin
      w_data = r_gpr[w_phys];
      if (BYPASS && wr_en && !reset && (w_wr_phys == w_phys))
        w_data = wr_data;
    end

    assign rd_data[32*k +: 32] = w_data;
  end

  assign cpsr = (BYPASS && flag_we && !reset) ? {flags_in, r_cpsr[27:0]} : r_cpsr;
  assign spsr = w_spsr_cur;

  // The exception LR write is issued last so it wins over a colliding wr_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS_GPR; i++) r_gpr[i] <= 32'h0;
    end else begin
      if (wr_en)      r_gpr[w_wr_phys] <= wr_data;
      if (w_exc_take) r_gpr[w_lr_phys] <= exc_lr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPSR; i++) r_spsr[i] <= 32'h0;
      r_cpsr <= {24'b0, 1'b1, 1'b1, 1'b0, RESET_MODE};
    end else if (w_exc_take) begin
      r_spsr[spsr_index(exc_mode)] <= w_cpsr_to_spsr;
      r_cpsr                       <= w_cpsr_exc;
    end else if (w_ret_take) begin
      r_cpsr <= w_spsr_cur & CPSR_MASK;
    end else if (flag_we) begin
      r_cpsr[CPSR_N:CPSR_V] <= flags_in;
    end
  end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed self-checking bench: default forwarding DUT plus a BYPASS=0
// single-port twin driven by the same write/control inputs.
module tb_arm_banked_regfile;

  logic         clock;
  logic         reset;
  logic [11:0]  rdAddr;
  logic [95:0]  rdData;
  logic [31:0]  rdDataNb;
  logic         wrEn;
  logic [3:0]   wrAddr;
  logic [31:0]  wrData;
  logic         flagWe;
  logic [3:0]   flagsIn;
  logic         excValid;
  logic [4:0]   excMode;
  logic [31:0]  excLr;
  logic         retValid;
  logic [31:0]  cpsrOut;
  logic [31:0]  spsrOut;
  logic [31:0]  cpsrNb;
  logic [31:0]  spsrNb;

  int testCount = 0;
  int failCount = 0;

  arm_banked_regfile dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rdAddr),
    .rd_data   (rdData),
    .wr_en     (wrEn),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .flag_we   (flagWe),
    .flags_in  (flagsIn),
    .exc_valid (excValid),
    .exc_mode  (excMode),
    .exc_lr    (excLr),
    .ret_valid (retValid),
    .cpsr      (cpsrOut),
    .spsr      (spsrOut)
  );

  arm_banked_regfile #(.NUM_RD(1), .BYPASS(1'b0)) dutNb (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rdAddr[3:0]),
    .rd_data   (rdDataNb),
    .wr_en     (wrEn),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .flag_we   (flagWe),
    .flags_in  (flagsIn),
    .exc_valid (excValid),
    .exc_mode  (excMode),
    .exc_lr    (excLr),
    .ret_valid (retValid),
    .cpsr      (cpsrNb),
    .spsr      (spsrNb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic fwe, input logic [3:0] fl,
                               input logic ev, input logic [4:0] em, input logic [31:0] el,
                               input logic rv);
    wrEn     = we;
    wrAddr   = wa;
    wrData   = wd;
    flagWe   = fwe;
    flagsIn  = fl;
    excValid = ev;
    excMode  = em;
    excLr    = el;
    retValid = rv;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset  = 1'b1;
    rdAddr = {4'd2, 4'd1, 4'd0};
    idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset_cpsr",  cpsrOut, 32'h000000D3);
    checkOutput("reset_spsr",  spsrOut, 32'h0);
    checkOutput("reset_rd0",   rdData[31:0],  32'h0);
    checkOutput("reset_rd1",   rdData[63:32], 32'h0);
    checkOutput("reset_rd2",   rdData[95:64], 32'h0);
    checkOutput("reset_cpsr_nb", cpsrNb, 32'h000000D3);

    // SVC R13 write, forwarded on the bypass DUT only
    rdAddr = {4'd2, 4'd1, 4'd13};
    applyStimulus(1'b1, 4'd13, 32'h1111_0000, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("svc_r13_bypass",    rdData[31:0], 32'h1111_0000);
    checkOutput("svc_r13_nobypass",  rdDataNb,     32'h0);
    tick();
    idle();
    #1;
    checkOutput("svc_r13_after",     rdData[31:0], 32'h1111_0000);
    checkOutput("svc_r13_after_nb",  rdDataNb,     32'h1111_0000);

    // R2 forwarding
    rdAddr = {4'd1, 4'd13, 4'd2};
    applyStimulus(1'b1, 4'd2, 32'hABCD_EF01, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("r2_bypass",   rdData[31:0], 32'hABCD_EF01);
    checkOutput("r2_nobypass", rdDataNb,     32'h0);
    tick();
    idle();
    #1;
    checkOutput("r2_after_nb", rdDataNb, 32'hABCD_EF01);

    // Exception entry SVC -> IRQ
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 5'b10010, 32'h0000_0018, 1'b0);
    tick();
    idle();
    rdAddr = {4'd2, 4'd14, 4'd13};
    #1;
    checkOutput("irq_cpsr", cpsrOut, 32'h000000D2);
    checkOutput("irq_spsr", spsrOut, 32'h000000D3);
    checkOutput("irq_r13",  rdData[31:0],  32'h0);
    checkOutput("irq_r14",  rdData[63:32], 32'h0000_0018);
    checkOutput("irq_r2",   rdData[95:64], 32'hABCD_EF01);

    // Return IRQ -> SVC
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("ret_cpsr",    cpsrOut, 32'h000000D3);
    checkOutput("ret_spsr",    spsrOut, 32'h0);
    checkOutput("ret_svc_r13", rdData[31:0],  32'h1111_0000);
    checkOutput("ret_svc_r14", rdData[63:32], 32'h0);

    // Flag update together with FIQ entry
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'b1010, 1'b1, 5'b10001, 32'h0000_001C, 1'b0);
    #1;
    checkOutput("flag_fwd_cpsr",    cpsrOut, 32'hA00000D3);
    checkOutput("flag_fwd_cpsr_nb", cpsrNb,  32'h000000D3);
    tick();
    idle();
    rdAddr = {4'd8, 4'd14, 4'd13};
    #1;
    checkOutput("fiq_spsr",      spsrOut, 32'hA00000D3);
    checkOutput("fiq_cpsr_low",  {24'h0, cpsrOut[7:0]}, 32'h000000D1);
    checkOutput("fiq_r13",       rdData[31:0],  32'h0);
    checkOutput("fiq_r14",       rdData[63:32], 32'h0000_001C);
    checkOutput("fiq_r8",        rdData[95:64], 32'h0);

    // FIQ-bank R8 write must not leak into the user R8
    applyStimulus(1'b1, 4'd8, 32'h0000_0055, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("fiq_r8_bypass", rdData[95:64], 32'h0000_0055);
    tick();
    idle();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("fiq_ret_cpsr",  cpsrOut, 32'hA00000D3);
    checkOutput("fiq_ret_spsr",  spsrOut, 32'h0);
    checkOutput("usr_r8_clean",  rdData[95:64], 32'h0);
    checkOutput("fiq_ret_r13",   rdData[31:0],  32'h1111_0000);

    // SVC -> SVC entry while writing R14: exc_lr wins
    applyStimulus(1'b1, 4'd14, 32'h0000_DEAD, 1'b0, 4'd0, 1'b1, 5'b10011, 32'h0000_0030, 1'b0);
    tick();
    idle();
    rdAddr = {4'd2, 4'd14, 4'd13};
    #1;
    checkOutput("lr_collide_r14",  rdData[63:32], 32'h0000_0030);
    checkOutput("lr_collide_spsr", spsrOut, 32'hA00000D3);
    checkOutput("lr_collide_cpsr", cpsrOut, 32'hA00000D3);

    // Illegal and USR exception modes are ignored
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 5'b10100, 32'h0000_0099, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("illegal_cpsr", cpsrOut, 32'hA00000D3);
    checkOutput("illegal_spsr", spsrOut, 32'hA00000D3);
    checkOutput("illegal_r14",  rdData[63:32], 32'h0000_0030);
    checkOutput("illegal_r13",  rdData[31:0],  32'h1111_0000);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 5'b10000, 32'h0000_0077, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("usr_exc_cpsr", cpsrOut, 32'hA00000D3);
    checkOutput("usr_exc_r14",  rdData[63:32], 32'h0000_0030);

    // Asynchronous reset between clock edges
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_cpsr", cpsrOut, 32'h000000D3);
    checkOutput("async_rst_spsr", spsrOut, 32'h0);
    checkOutput("async_rst_rd0",  rdData[31:0],  32'h0);
    checkOutput("async_rst_rd1",  rdData[63:32], 32'h0);
    checkOutput("async_rst_rd2",  rdData[95:64], 32'h0);
    checkOutput("async_rst_nb",   rdDataNb, 32'h0);
    reset = 1'b0;
    #1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
